// File: rtl/grad_nms_packer.sv
// grad_nms_packer
//
// Turns a stream of signed Sobel gradient pairs {gy, gx} into packed
// magnitude/direction words for non-maximum suppression, and watches the
// input line structure for length violations.
//
// Ports
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   s_tdata             : {gy, gx}, each GRAD_WIDTH bits, two's complement
//   s_tvalid/s_tready   : input handshake
//   s_tuser/s_tlast     : start of frame / end of line, carried with the beat
//   m_tdata             : {1'b0, dir[2:0], mag[11:0]}
//   m_tvalid/m_tready   : output handshake
//   m_tuser/m_tlast     : sideband of the beat currently on m_tdata
//   err_clr             : synchronous clear of err_line_len
//   err_line_len        : sticky flag, set when a line is not IMG_WIDTH long
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high. A master holds valid and its payload stable until that edge and never
// waits for ready before raising valid. Ready may change at any cycle.
//
// Direction codes: 0 = near horizontal gradient (|gy|/|gx| <= ~0.414),
// 2 = near vertical (|gy|/|gx| >= ~2.414), 1 = diagonal with matching signs,
// 3 = anti-diagonal. Tangent thresholds are scaled by 256 so the comparison is
// pure integer multiply.

module grad_nms_packer #(
    parameter int GRAD_WIDTH = 11,
    parameter int DATA_WIDTH = 12,
    parameter int DIR_WIDTH  = 3,
    parameter int IMG_WIDTH  = 1920
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [2*GRAD_WIDTH-1:0]   s_tdata,
    input  logic                      s_tvalid,
    input  logic                      s_tuser,
    input  logic                      s_tlast,
    output logic                      s_tready,
    output logic [15:0]               m_tdata,
    output logic                      m_tvalid,
    output logic                      m_tuser,
    output logic                      m_tlast,
    input  logic                      m_tready,
    input  logic                      err_clr,
    output logic                      err_line_len
);

    // Product width: ax*618 needs GRAD_WIDTH+10 bits, which covers the others.
    localparam int PW = GRAD_WIDTH + 10;
    localparam int SW = GRAD_WIDTH + 1;
    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
    localparam logic [31:0]   MAG_MAX  = 32'((64'd1 << DATA_WIDTH) - 64'd1);

    // ------------------------------------------------------------------
    // Handshake / advance control
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s2_ready;
    logic s1_advance;
    logic accept;

    // Stage 2 is the output register; it can take new data when it is empty
    // or its beat leaves this cycle. Stage 1 drains into stage 2 under the
    // same condition.
    assign s2_ready   = ~m_tvalid | m_tready;
    assign s1_advance = s1_valid & s2_ready;
    assign s_tready   = ~s1_valid | s1_advance;
    assign accept     = s_tvalid & s_tready;

    // ------------------------------------------------------------------
    // Stage 1: absolute values, scaled products, signs, sideband
    // ------------------------------------------------------------------
    logic [GRAD_WIDTH-1:0] gx, gy;
    logic [GRAD_WIDTH-1:0] ax, ay;

    assign gx = s_tdata[GRAD_WIDTH-1:0];
    assign gy = s_tdata[2*GRAD_WIDTH-1:GRAD_WIDTH];
    // Negating the most negative value yields the same bit pattern, which
    // read as unsigned is exactly 2^(GRAD_WIDTH-1).
    assign ax = gx[GRAD_WIDTH-1] ? -gx : gx;
    assign ay = gy[GRAD_WIDTH-1] ? -gy : gy;

    logic [GRAD_WIDTH-1:0] s1_ax, s1_ay;
    logic [PW-1:0]         s1_ay256, s1_ax106, s1_ax618;
    logic                  s1_sx, s1_sy, s1_user, s1_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_ax    <= '0;
            s1_ay    <= '0;
            s1_ay256 <= '0;
            s1_ax106 <= '0;
            s1_ax618 <= '0;
            s1_sx    <= 1'b0;
            s1_sy    <= 1'b0;
            s1_user  <= 1'b0;
            s1_last  <= 1'b0;
        end else if (s_tready) begin
            s1_valid <= s_tvalid;
            if (s_tvalid) begin
                s1_ax    <= ax;
                s1_ay    <= ay;
                s1_ay256 <= PW'(ay) << 8;
                s1_ax106 <= PW'(ax) * PW'(106);
                s1_ax618 <= PW'(ax) * PW'(618);
                s1_sx    <= gx[GRAD_WIDTH-1];
                s1_sy    <= gy[GRAD_WIDTH-1];
                s1_user  <= s_tuser;
                s1_last  <= s_tlast;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: saturated magnitude, direction code, packing
    // ------------------------------------------------------------------
    logic [SW-1:0]        sum;
    logic [11:0]          mag_field;
    logic [DIR_WIDTH-1:0] dir;

    always_comb begin
        sum = SW'(s1_ax) + SW'(s1_ay);
        if (32'(sum) > MAG_MAX) begin
            mag_field = 12'(MAG_MAX);
        end else begin
            mag_field = 12'(sum);
        end

        // The first test also catches gx=gy=0 (0 <= 0); gx=0 with gy!=0
        // falls through to the vertical code.
        if (s1_ay256 <= s1_ax106) begin
            dir = DIR_WIDTH'(0);
        end else if (s1_ay256 >= s1_ax618) begin
            dir = DIR_WIDTH'(2);
        end else if (s1_sx == s1_sy) begin
            dir = DIR_WIDTH'(1);
        end else begin
            dir = DIR_WIDTH'(3);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tuser  <= 1'b0;
            m_tlast  <= 1'b0;
        end else if (s2_ready) begin
            m_tvalid <= s1_valid;
            if (s1_valid) begin
                m_tdata <= {1'b0, 3'(dir), mag_field};
                m_tuser <= s1_user;
                m_tlast <= s1_last;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line length monitor (status only, never stalls the stream)
    // ------------------------------------------------------------------
    logic [CW-1:0] col;
    logic [CW-1:0] cur_col;
    logic          at_last_col;
    logic          violation;

    // A start-of-frame beat is column 0 regardless of the running count.
    assign cur_col     = s_tuser ? '0 : col;
    assign at_last_col = (cur_col == LAST_COL);
    // Early end (tlast before the last column) or missing end (last column
    // without tlast) are both a mismatch between tlast and the column.
    assign violation   = accept & (s_tlast != at_last_col);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col          <= '0;
            err_line_len <= 1'b0;
        end else begin
            if (accept) begin
                col <= (s_tlast || at_last_col) ? '0 : cur_col + CW'(1);
            end
            // A new violation wins over a coincident clear.
            err_line_len <= (err_line_len & ~err_clr) | violation;
        end
    end

endmodule
